flash_rx: RTL and testbench

Receiver for an active-low stretched "flash" line, as driven by the board's pulse stretchers, front-panel indicator lines and inter-board busy/flash signals.
- Synchronizes the asynchronous line into the `clk` domain and rejects glitches shorter than `MIN_LEN` cycles.
- Emits a one-cycle `trig` on each qualified flash and reports the flash width in clock cycles when the line releases.
- Optionally flags a line stuck low.

---
 rtl/flash_rx.sv | 143 ++++++++++++++
 tb/tb_flash_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_rx.sv
// +--------------------------------------------------------------------------+
// | flash_rx : receiver for an active-low stretched flash line.              |
// | Two-flop synchronizer, glitch qualification (MIN_LEN), width report and  |
// | optional stuck-low detection when FLASH_RX_TIMEOUT_EN is defined.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module flash_rx #(
    parameter int unsigned MIN_LEN = 4,
    parameter int unsigned MAX_LEN = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in,
    output logic        trig,
    output logic        done,
    output logic [15:0] width,
    output logic        busy,
    output logic        stuck
);

    if (MIN_LEN < 1 || MIN_LEN > 255 || MAX_LEN <= MIN_LEN || MAX_LEN > 65534) begin : g_param_chk
        $error("flash_rx: MIN_LEN/MAX_LEN out of legal range");
    end

    localparam logic [15:0] c_MIN = 16'(MIN_LEN);
`ifdef FLASH_RX_TIMEOUT_EN
    localparam logic [15:0] c_MAX = 16'(MAX_LEN);
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_ACTIVE = 2'd2
`ifdef FLASH_RX_TIMEOUT_EN
        ,
        ST_STUCK  = 2'd3
`endif
    } state_t;

    state_t      r_state;
    logic        r_s1;
    logic        r_s0;
    logic [15:0] r_cnt;
    logic [15:0] r_width;
    logic        r_trig;
    logic        r_done;
    logic        r_busy;
    logic [15:0] w_cnt_inc;

    // Low-sample counter pins at all-ones rather than wrapping.
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

`ifdef FLASH_RX_TIMEOUT_EN
    logic r_stuck;
    assign stuck = r_stuck;
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b1;
            r_s0    <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_width <= 16'd0;
            r_trig  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef FLASH_RX_TIMEOUT_EN
            r_stuck <= 1'b0;
`endif
        end else begin
            r_s1   <= in;
            r_s0   <= r_s1;
            r_trig <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_s0) begin
                        r_cnt <= 16'd1;
                        if (c_MIN == 16'd1) begin
                            r_state <= ST_ACTIVE;
                            r_trig  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_QUAL;
                        end
                    end
                end
                ST_QUAL: begin
                    if (r_s0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_MIN) begin
                            r_state <= ST_ACTIVE;
                            r_trig  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (r_s0) begin
                        r_width <= r_cnt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
`ifdef FLASH_RX_TIMEOUT_EN
                        if (w_cnt_inc == c_MAX) begin
                            r_state <= ST_STUCK;
                            r_stuck <= 1'b1;
                            r_busy  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef FLASH_RX_TIMEOUT_EN
                ST_STUCK: begin
                    // Release from a stuck line is silent: no width, no done.
                    if (r_s0) begin
                        r_state <= ST_IDLE;
                        r_stuck <= 1'b0;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign trig  = r_trig;
    assign done  = r_done;
    assign busy  = r_busy;
    assign width = r_width;

endmodule

`default_nettype wire

// File: tb/tb_flash_rx.sv
// +--------------------------------------------------------------------------+
// | tb_flash_rx : directed, table-driven bench for flash_rx (MIN_LEN 4 and 1).|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_flash_rx;

`ifdef FLASH_RX_TIMEOUT_EN
    localparam int c_AMAX = 100;
`else
    localparam int c_AMAX = 50000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in = 1'b1;
    logic        a_trig, a_done, a_busy, a_stuck;
    logic [15:0] a_width;
    logic        b_trig, b_done, b_busy, b_stuck;
    logic [15:0] b_width;

    flash_rx #(.MIN_LEN(4), .MAX_LEN(c_AMAX)) u_a (
        .clk(clk), .rst_n(rst_n), .in(in), .trig(a_trig), .done(a_done),
        .width(a_width), .busy(a_busy), .stuck(a_stuck)
    );

    flash_rx #(.MIN_LEN(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in(in), .trig(b_trig), .done(b_done),
        .width(b_width), .busy(b_busy), .stuck(b_stuck)
    );

    always #5 clk = ~clk;

    int pcnt = 0;
    always @(posedge clk) pcnt++;

    int checks = 0;
    int errors = 0;

    int a_trig_n, a_done_n, a_busy_n, a_stuck_n, a_trig_pc, a_done_pc, a_stuck_pc, a_w1, a_w2;
    int b_trig_n, b_done_n, b_busy_n, b_trig_pc, b_done_pc, b_w1;
    int overlap_n = 0;
    int stuck_total = 0;

    always @(negedge clk) begin
        if (a_trig) begin
            if (a_trig_n == 0) a_trig_pc = pcnt;
            a_trig_n++;
        end
        if (a_done) begin
            if (a_done_n == 0) begin a_done_pc = pcnt; a_w1 = int'(a_width); end
            else a_w2 = int'(a_width);
            a_done_n++;
        end
        if (a_busy) a_busy_n++;
        if (a_stuck) begin
            if (a_stuck_n == 0) a_stuck_pc = pcnt;
            a_stuck_n++;
            stuck_total++;
        end
        if (b_trig) begin
            if (b_trig_n == 0) b_trig_pc = pcnt;
            b_trig_n++;
        end
        if (b_done) begin
            if (b_done_n == 0) begin b_done_pc = pcnt; b_w1 = int'(b_width); end
            b_done_n++;
        end
        if (b_busy) b_busy_n++;
        if (b_stuck) stuck_total++;
        if ((a_trig && a_done) || (b_trig && b_done)) overlap_n++;
    end

    task automatic clr();
        a_trig_n = 0; a_done_n = 0; a_busy_n = 0; a_stuck_n = 0;
        a_trig_pc = -1; a_done_pc = -1; a_stuck_pc = -1; a_w1 = -1; a_w2 = -1;
        b_trig_n = 0; b_done_n = 0; b_busy_n = 0; b_trig_pc = -1; b_done_pc = -1; b_w1 = -1;
    endtask

    // Drive changes land 1 time unit after a falling edge, after the monitor sampled.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int n;
        int a_trig;
        int a_width;
        int a_busy;
        int b_width;
    } vec_t;

    vec_t vt[6];
    int   p0;

    initial begin
        // Synchronous lows of n cycles; A qualifies at 4, B at 1.
        vt[0] = '{n: 1,  a_trig: 0, a_width: 0,  a_busy: 0, b_width: 1};
        vt[1] = '{n: 2,  a_trig: 0, a_width: 0,  a_busy: 0, b_width: 2};
        vt[2] = '{n: 3,  a_trig: 0, a_width: 0,  a_busy: 0, b_width: 3};
        vt[3] = '{n: 4,  a_trig: 1, a_width: 4,  a_busy: 1, b_width: 4};
        vt[4] = '{n: 10, a_trig: 1, a_width: 10, a_busy: 7, b_width: 10};
        vt[5] = '{n: 5,  a_trig: 1, a_width: 5,  a_busy: 2, b_width: 5};

        clr();
        rst_n = 1'b0;
        in    = 1'b1;
        tick(3);
        chk("rst_width_a", int'(a_width), 0);
        chk("rst_busy_a", int'(a_busy), 0);
        rst_n = 1'b1;
        clr();
        tick(100);
        chk("idle_trig_a", a_trig_n, 0);
        chk("idle_done_a", a_done_n, 0);
        chk("idle_busy_a", a_busy_n, 0);
        chk("idle_width_a", int'(a_width), 0);
        chk("idle_trig_b", b_trig_n, 0);
        chk("idle_width_b", int'(b_width), 0);

        for (int i = 0; i < 6; i++) begin
            clr();
            p0 = pcnt;
            in = 1'b0;
            tick(vt[i].n);
            in = 1'b1;
            tick(8);
            chk($sformatf("v%0d_trig_a", i), a_trig_n, vt[i].a_trig);
            chk($sformatf("v%0d_done_a", i), a_done_n, vt[i].a_trig);
            chk($sformatf("v%0d_width_a", i), int'(a_width), vt[i].a_width);
            chk($sformatf("v%0d_busy_a", i), a_busy_n, vt[i].a_busy);
            if (vt[i].a_trig != 0) begin
                chk($sformatf("v%0d_trig_lat_a", i), a_trig_pc - p0, 6);
                chk($sformatf("v%0d_done_lat_a", i), a_done_pc - p0, vt[i].n + 3);
            end
            chk($sformatf("v%0d_trig_b", i), b_trig_n, 1);
            chk($sformatf("v%0d_width_b", i), b_w1, vt[i].b_width);
            chk($sformatf("v%0d_busy_b", i), b_busy_n, vt[i].n);
            chk($sformatf("v%0d_trig_lat_b", i), b_trig_pc - p0, 3);
        end

        // Back-to-back 6-cycle lows with a single idle-high cycle between them.
        clr();
        in = 1'b0; tick(6);
        in = 1'b1; tick(1);
        in = 1'b0; tick(6);
        in = 1'b1; tick(8);
        chk("b2b_trig_a", a_trig_n, 2);
        chk("b2b_done_a", a_done_n, 2);
        chk("b2b_w1_a", a_w1, 6);
        chk("b2b_w2_a", a_w2, 6);
        chk("b2b_done_b", b_done_n, 2);

        // Reset pulse in the middle of a 20-cycle low; 11 low cycles follow release.
        clr();
        in = 1'b0; tick(8);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy_a", int'(a_busy), 0);
        chk("midrst_width_a", int'(a_width), 0);
        chk("midrst_trig_done_a", int'(a_trig | a_done), 0);
        tick(1);
        rst_n = 1'b1;
        tick(11);
        in = 1'b1;
        tick(8);
        chk("midrst_trigs_a", a_trig_n, 2);
        chk("midrst_dones_a", a_done_n, 1);
        chk("midrst_post_width_a", int'(a_width), 11);
        chk("midrst_post_width_b", int'(b_width), 11);

`ifdef FLASH_RX_TIMEOUT_EN
        clr();
        p0 = pcnt;
        in = 1'b0; tick(150);
        in = 1'b1; tick(8);
        chk("stk_trig_a", a_trig_n, 1);
        chk("stk_done_a", a_done_n, 0);
        chk("stk_first_a", a_stuck_pc - p0, 102);
        chk("stk_len_a", a_stuck_n, 51);
        chk("stk_width_held_a", int'(a_width), 11);
        chk("stk_width_b", b_w1, 150);
`else
        clr();
        in = 1'b0; tick(70000);
        in = 1'b1; tick(8);
        chk("sat_trig_a", a_trig_n, 1);
        chk("sat_done_a", a_done_n, 1);
        chk("sat_width_a", int'(a_width), 65535);
        chk("sat_width_b", int'(b_width), 65535);
        chk("nostuck", stuck_total, 0);
`endif

        chk("trig_done_overlap", overlap_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
